// File: rtl/alu_seq_exec.sv
// EX-stage ALU with start/done handshake; logic/arith in 1 cycle, shifts iterate one bit per cycle.
// Define ALU_SEQ_BARREL_EN to replace the iterative shifter with a 1-cycle barrel shifter.
module alu_seq_exec #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [3:0]         alu_op,
  input  logic               shift,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               overflow,
  output logic               illegal
);

  localparam logic [3:0] OP_ADD  = 4'b1110;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1010;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_PASS = 4'b1100;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t               state_q, state_d;
  logic [SHAMT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]     work_q, work_d;
  logic [3:0]           op_q, op_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 zero_q, zero_d;
  logic                 ovf_q, ovf_d;
  logic                 illegal_q, illegal_d;
  logic                 done_q, done_d;

  logic signed [WIDTH-1:0] sa, sb, sum, diff;
  logic                    legal_op, is_shift_op, bad_op;
  logic                    fin, fin_ovf;
  logic [WIDTH-1:0]        fin_res;

  function automatic logic add_ovf(input logic signed [WIDTH-1:0] a, b, s);
    return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
  endfunction

  function automatic logic sub_ovf(input logic signed [WIDTH-1:0] a, b, d);
    return (a[WIDTH-1] != b[WIDTH-1]) && (d[WIDTH-1] != a[WIDTH-1]);
  endfunction

  // One-bit step of the iterative shifter; SRA replicates the sign bit.
  function automatic logic [WIDTH-1:0] shift1(input logic [3:0] op, input logic [WIDTH-1:0] v);
    case (op)
      OP_SLL:  return {v[WIDTH-2:0], 1'b0};
      OP_SRL:  return {1'b0, v[WIDTH-1:1]};
      default: return {v[WIDTH-1], v[WIDTH-1:1]};
    endcase
  endfunction

  assign sa   = op_a;
  assign sb   = op_b;
  assign sum  = sa + sb;
  assign diff = sa - sb;

  always_comb begin
    legal_op    = 1'b1;
    is_shift_op = 1'b0;
    case (alu_op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_PASS: is_shift_op = 1'b0;
      OP_SLL, OP_SRL, OP_SRA:                         is_shift_op = 1'b1;
      default:                                        legal_op    = 1'b0;
    endcase
    bad_op = !legal_op || (shift != is_shift_op);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    op_d      = op_q;
    result_d  = result_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    illegal_d = illegal_q;
    done_d    = 1'b0;
    fin       = 1'b0;
    fin_res   = '0;
    fin_ovf   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          illegal_d = bad_op;
          if (bad_op) begin
            fin = 1'b1;
          end else if (is_shift_op) begin
`ifdef ALU_SEQ_BARREL_EN
            fin = 1'b1;
            case (alu_op)
              OP_SLL:  fin_res = op_b << shamt;
              OP_SRL:  fin_res = op_b >> shamt;
              default: fin_res = sb >>> shamt;
            endcase
`else
            if (shamt == '0) begin
              fin     = 1'b1;
              fin_res = op_b;
            end else begin
              state_d = SHIFT;
              work_d  = op_b;
              cnt_d   = shamt;
              op_d    = alu_op;
            end
`endif
          end else begin
            fin = 1'b1;
            case (alu_op)
              OP_ADD: begin fin_res = sum;  fin_ovf = add_ovf(sa, sb, sum);  end
              OP_SUB: begin fin_res = diff; fin_ovf = sub_ovf(sa, sb, diff); end
              OP_AND:  fin_res = op_a & op_b;
              OP_OR:   fin_res = op_a | op_b;
              OP_XOR:  fin_res = op_a ^ op_b;
              default: fin_res = op_a;
            endcase
          end
        end
      end
      SHIFT: begin
        work_d = shift1(op_q, work_q);
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == SHAMT_W'(1)) begin
          fin     = 1'b1;
          fin_res = shift1(op_q, work_q);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Result and its flags are committed together on every completion.
    if (fin) begin
      result_d = fin_res;
      zero_d   = (fin_res == '0);
      ovf_d    = fin_ovf;
      done_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      work_q    <= '0;
      op_q      <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      illegal_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      op_q      <= op_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      ovf_q     <= ovf_d;
      illegal_q <= illegal_d;
      done_q    <= done_d;
    end
  end

  assign busy     = (state_q == SHIFT);
  assign done     = done_q;
  assign result   = result_q;
  assign zero     = zero_q;
  assign overflow = ovf_q;
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Directed-vector bench for alu_seq_exec (default iterative-shifter build).
module tb_alu_seq_exec;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  alu_op;
  logic        shift;
  logic [31:0] op_a, op_b;
  logic [4:0]  shamt;
  logic        busy, done, zero, overflow, illegal;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;
  int lat, bcnt, dcnt;

  alu_seq_exec #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alu_op(alu_op), .shift(shift),
    .op_a(op_a), .op_b(op_b), .shamt(shamt), .busy(busy), .done(done),
    .result(result), .zero(zero), .overflow(overflow), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic sh, input logic [31:0] a, b,
                       input logic [4:0] sa);
    alu_op = op; shift = sh; op_a = a; op_b = b; shamt = sa;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Cycles counted from acceptance: lat=1 is the cycle right after the accepting edge.
  task automatic wait_done(input int lat0, input int maxc, output int l, output int bc);
    l  = lat0;
    bc = 0;
    while (!done && l < maxc) begin
      if (busy) bc++;
      step();
      l++;
    end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0; alu_op = '0; shift = 1'b0; op_a = '0; op_b = '0; shamt = '0;
    for (int i = 0; i < 4; i++) begin
      start = 1'($urandom); alu_op = 4'($urandom); shift = 1'($urandom);
      op_a = $urandom; op_b = $urandom; shamt = 5'($urandom);
      step();
    end
    chk("rst_result", result, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_flags", {29'd0, zero, overflow, illegal}, 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    step(); step();
    chk("idle_result", result, 32'h0);
    chk("idle_ctl", {28'd0, busy, done, zero, overflow | illegal}, 32'd0);

    // Arithmetic and logic: single-cycle.
    issue(4'b1110, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0);
    wait_done(1, 4, lat, bcnt);
    chk("add_lat", lat, 1);
    chk("add_res", result, 32'h8000_0000);
    chk("add_flags", {30'd0, overflow, zero}, 32'b10);
    step();
    chk("add_done_pulse", {31'd0, done}, 32'd0);
    chk("add_hold", result, 32'h8000_0000);

    issue(4'b0100, 1'b0, 32'd5, 32'd5, 5'd0);
    wait_done(1, 4, lat, bcnt);
    chk("sub_lat", lat, 1);
    chk("sub_res", result, 32'h0);
    chk("sub_flags", {30'd0, overflow, zero}, 32'b01);

    issue(4'b0100, 1'b0, 32'h8000_0000, 32'h0000_0001, 5'd0);
    wait_done(1, 4, lat, bcnt);
    chk("sub_ovf_res", result, 32'h7FFF_FFFF);
    chk("sub_ovf", {31'd0, overflow}, 32'd1);

    issue(4'b0010, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0);
    wait_done(1, 4, lat, bcnt);
    chk("and_res", result, 32'h00F0_1200);
    issue(4'b0011, 1'b0, 32'hF000_0001, 32'h0000_0F00, 5'd0);
    wait_done(1, 4, lat, bcnt);
    chk("or_res", result, 32'hF000_0F01);
    issue(4'b1100, 1'b0, 32'hDEAD_BEEF, 32'h1111_1111, 5'd0);
    wait_done(1, 4, lat, bcnt);
    chk("pass_res", result, 32'hDEAD_BEEF);
    chk("pass_ovf", {31'd0, overflow}, 32'd0);

    // Iterative shifts.
    issue(4'b1001, 1'b1, 32'h0, 32'h8000_0000, 5'd4);
    wait_done(1, 40, lat, bcnt);
    chk("sra_lat", lat, 5);
    chk("sra_busy_cycles", bcnt, 4);
    chk("sra_res", result, 32'hF800_0000);
    chk("sra_busy_at_done", {31'd0, busy}, 32'd0);

    issue(4'b1010, 1'b1, 32'h0, 32'h0000_0001, 5'd31);
    wait_done(1, 40, lat, bcnt);
    chk("sll_lat", lat, 32);
    chk("sll_res", result, 32'h8000_0000);

    issue(4'b1000, 1'b1, 32'h0, 32'h0000_1234, 5'd0);
    wait_done(1, 4, lat, bcnt);
    chk("srl0_lat", lat, 1);
    chk("srl0_busy", {31'd0, busy}, 32'd0);
    chk("srl0_res", result, 32'h0000_1234);

    // Starts during a shift are ignored; a start in the done cycle is accepted.
    issue(4'b1000, 1'b1, 32'h0, 32'hF000_0000, 5'd10);
    for (int i = 0; i < 3; i++) begin
      alu_op = 4'b1110; shift = 1'b0; op_a = 32'd1; op_b = 32'd1; shamt = 5'd0;
      start = 1'b1;
      step();
      start = 1'b0;
    end
    wait_done(4, 40, lat, bcnt);
    chk("srl10_lat", lat, 11);
    chk("srl10_res", result, 32'h003C_0000);
    issue(4'b0111, 1'b0, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd0);
    chk("b2b_done", {31'd0, done}, 32'd1);
    chk("b2b_res", result, 32'hF0F0_F0F0);

    // Illegal encodings.
    issue(4'b0000, 1'b0, 32'h1234_5678, 32'h1, 5'd3);
    wait_done(1, 4, lat, bcnt);
    chk("ill_op_lat", lat, 1);
    chk("ill_op_flag", {31'd0, illegal}, 32'd1);
    chk("ill_op_res", result, 32'h0);
    issue(4'b0010, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
    wait_done(1, 4, lat, bcnt);
    chk("ill_and_flag", {31'd0, illegal}, 32'd1);
    chk("ill_and_res", result, 32'h0);
    step();
    chk("ill_held", {31'd0, illegal}, 32'd1);
    issue(4'b1110, 1'b0, 32'd2, 32'd3, 5'd0);
    wait_done(1, 4, lat, bcnt);
    chk("ill_cleared", {31'd0, illegal}, 32'd0);
    chk("add_small_res", result, 32'd5);

    // Reset mid-shift aborts without a late done.
    issue(4'b1010, 1'b1, 32'h0, 32'h0000_0001, 5'd20);
    step(); step(); step();
    chk("pre_abort_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    step();
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 25; i++) begin
      if (done) dcnt++;
      step();
    end
    chk("abort_no_done", dcnt, 0);
    chk("abort_result", result, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
